// File: rtl/fp_round_sched_if.sv
// fp_round_sched_if: request/response bundle for the shared FP rounding scheduler.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_mant/req_exp    : packed operands, slice i = [27*i +: 27] and [8*i +: 8]
//   rsp_valid/rsp_ready : result handshake towards the pack stage
//   rsp_id/rsp_mant/rsp_exp/rsp_ovf : owner index and rounded result
// master = requesters plus consumer, slave = scheduler.
interface fp_round_sched_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [27*N_REQ-1:0] req_mant;
   logic [8*N_REQ-1:0]  req_exp;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [ID_W-1:0]     rsp_id;
   logic [22:0]         rsp_mant;
   logic [7:0]          rsp_exp;
   logic                rsp_ovf;

   modport master (
      output req_valid, req_mant, req_exp, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_mant, rsp_exp, rsp_ovf
   );

   modport slave (
      input  req_valid, req_mant, req_exp, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_mant, rsp_exp, rsp_ovf
   );
endinterface

// File: rtl/fp_round_sched.sv
// fp_round_sched: round-robin scheduler sharing one round-to-nearest-even stage between
// N_REQ normalised FP operand sources.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : fp_round_sched_if.slave (request arbitration in, rounded result out)
//   busy  : high whenever the scheduler is not idle
// Optional build macro FP_ROUND_SCHED_STATS_EN adds saturating 32-bit counters
//   stat_ops (completed results) and stat_ovf (completed results with rsp_ovf set).
// Flow: IDLE grants a request, ROUND evaluates rounding from the operand registers,
// HOLD presents the result and may grant the next request in the same cycle.
module fp_round_sched #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   fp_round_sched_if.slave bus,
`ifdef FP_ROUND_SCHED_STATS_EN
   output logic [31:0]     stat_ops,
   output logic [31:0]     stat_ovf,
`endif
   output logic            busy
);
   localparam int unsigned SumW = ID_W + 1;

   typedef enum logic [1:0] {StIdle, StRound, StHold} state_e;

   state_e           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [26:0]      op_mant_q, op_mant_d;
   logic [7:0]       op_exp_q, op_exp_d;
   logic [ID_W-1:0]  op_id_q, op_id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [22:0]      rsp_mant_q, rsp_mant_d;
   logic [7:0]       rsp_exp_q, rsp_exp_d;
   logic             rsp_ovf_q, rsp_ovf_d;
   logic             busy_q, busy_d;
   logic [N_REQ-1:0] req_ready_c;
   logic             grant;

   // Arbitration
   logic [ID_W-1:0]  next_ptr, arb_base, arb_idx, cand;
   logic [SumW-1:0]  cand_sum;
   logic             arb_found;
   logic [26:0]      arb_mant;
   logic [7:0]       arb_exp;

   assign next_ptr = (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
   // In HOLD the search must already start after the owner of the result leaving this cycle.
   assign arb_base = (state_q == StHold) ? next_ptr : rr_ptr_q;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      cand_sum  = '0;
      arb_mant  = '0;
      arb_exp   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         // Explicit wrap so non-power-of-two N_REQ never yields an out-of-range index.
         cand_sum = {1'b0, arb_base} + SumW'(k);
         cand     = (cand_sum >= SumW'(N_REQ)) ? ID_W'(cand_sum - SumW'(N_REQ)) : ID_W'(cand_sum);
         if (!arb_found && bus.req_valid[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (arb_idx == ID_W'(i)) begin
            arb_mant = bus.req_mant[27*i +: 27];
            arb_exp  = bus.req_exp[8*i +: 8];
         end
      end
   end

   // Rounding: 1.F with guard/round/sticky in [2:0], round half to even.
   logic        round_up;
   logic [24:0] round_sum;
   logic        round_carry;
   logic [22:0] rounded_mant;
   logic [7:0]  rounded_exp;
   logic        round_causes_overflow;

   assign round_up    = op_mant_q[2] & (op_mant_q[3] | op_mant_q[1] | op_mant_q[0]);
   assign round_sum   = {1'b0, op_mant_q[26:3]} + {24'd0, round_up};
   assign round_carry = round_sum[24];
   // A carry means 1.11..1 rounded to 10.00..0: renormalise by one and bump the exponent.
   assign rounded_mant          = round_carry ? round_sum[23:1] : round_sum[22:0];
   assign rounded_exp           = op_exp_q + {7'd0, round_carry};
   assign round_causes_overflow = round_carry & (rounded_exp == 8'hFF);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      op_mant_d   = op_mant_q;
      op_exp_d    = op_exp_q;
      op_id_d     = op_id_q;
      rsp_id_d    = rsp_id_q;
      rsp_mant_d  = rsp_mant_q;
      rsp_exp_d   = rsp_exp_q;
      rsp_ovf_d   = rsp_ovf_q;
      req_ready_c = '0;
      grant       = 1'b0;
      unique case (state_q)
         StIdle: grant = arb_found;
         StRound: begin
            rsp_mant_d = rounded_mant;
            rsp_exp_d  = rounded_exp;
            rsp_ovf_d  = round_causes_overflow;
            rsp_id_d   = op_id_q;
            state_d    = StHold;
         end
         StHold: begin
            if (bus.rsp_ready) begin
               rr_ptr_d = next_ptr;
               grant    = arb_found;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (grant) begin
         req_ready_c[arb_idx] = 1'b1;
         op_mant_d            = arb_mant;
         op_exp_d             = arb_exp;
         op_id_d              = arb_idx;
         state_d              = StRound;
      end
      rsp_valid_d = (state_d == StHold);
      busy_d      = (state_d != StIdle);
      // No handshake may complete on a reset edge.
      if (!rst_n) begin
         req_ready_c = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         op_mant_q   <= '0;
         op_exp_q    <= '0;
         op_id_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_mant_q  <= '0;
         rsp_exp_q   <= '0;
         rsp_ovf_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         op_mant_q   <= op_mant_d;
         op_exp_q    <= op_exp_d;
         op_id_q     <= op_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_mant_q  <= rsp_mant_d;
         rsp_exp_q   <= rsp_exp_d;
         rsp_ovf_q   <= rsp_ovf_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_mant  = rsp_mant_q;
   assign bus.rsp_exp   = rsp_exp_q;
   assign bus.rsp_ovf   = rsp_ovf_q;
   assign busy          = busy_q;

`ifdef FP_ROUND_SCHED_STATS_EN
   logic        rsp_fire;
   logic [31:0] stat_ops_q, stat_ops_d;
   logic [31:0] stat_ovf_q, stat_ovf_d;

   assign rsp_fire = rsp_valid_q & bus.rsp_ready;

   always_comb begin
      stat_ops_d = stat_ops_q;
      stat_ovf_d = stat_ovf_q;
      if (rsp_fire && (stat_ops_q != 32'hFFFF_FFFF)) begin
         stat_ops_d = stat_ops_q + 32'd1;
      end
      if (rsp_fire && rsp_ovf_q && (stat_ovf_q != 32'hFFFF_FFFF)) begin
         stat_ovf_d = stat_ovf_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_ops_q <= '0;
         stat_ovf_q <= '0;
      end else begin
         stat_ops_q <= stat_ops_d;
         stat_ovf_q <= stat_ovf_d;
      end
   end

   assign stat_ops = stat_ops_q;
   assign stat_ovf = stat_ovf_q;
`else
   // Statistics compiled out; scheduling and rounding are unaffected.
`endif
endmodule

// File: tb/tb_fp_round_sched.sv
// Self-checking bench for fp_round_sched: a negedge monitor predicts grants and pushes
// expected rounded results into a scoreboard queue, popped on each response handshake.
module tb_fp_round_sched;
   localparam int NReq = 4;
   localparam int IdW  = 2;

   typedef struct {
      logic [1:0]  id;
      logic [22:0] mant;
      logic [7:0]  exp;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy;
`ifdef FP_ROUND_SCHED_STATS_EN
   logic [31:0] stat_ops;
   logic [31:0] stat_ovf;
`endif
   logic [26:0] tm [NReq];
   logic [7:0]  te [NReq];

   fp_round_sched_if #(.N_REQ(NReq), .ID_W(IdW)) bus ();

   assign bus.req_mant = {tm[3], tm[2], tm[1], tm[0]};
   assign bus.req_exp  = {te[3], te[2], te[1], te[0]};

   fp_round_sched #(.N_REQ(NReq), .ID_W(IdW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
`ifdef FP_ROUND_SCHED_STATS_EN
      .stat_ops (stat_ops),
      .stat_ovf (stat_ovf),
`endif
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   int          model_ptr = 0;
   logic        prev_rst = 1'b0;
   exp_t        exp_q [$];
   logic [1:0]  id_log [$];
   int          hs_log [$];
   logic [31:0] data_log [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Reference rounding: {ovf, exp, frac}, round half to even on the G/R/S bits.
   function automatic logic [31:0] ref_round(input logic [26:0] m, input logic [7:0] e);
      logic [23:0] sig;
      logic [2:0]  grs;
      logic        up;
      logic [24:0] s;
      logic [7:0]  eo;
      logic [22:0] fo;
      logic        ov;
      sig = m[26:3];
      grs = m[2:0];
      up  = (grs > 3'b100) || ((grs == 3'b100) && sig[0]);
      s   = {1'b0, sig} + 25'(up);
      ov  = 1'b0;
      if (s[24]) begin
         fo = '0;
         eo = e + 8'd1;
         ov = (eo == 8'hFF);
      end else begin
         fo = s[22:0];
         eo = e;
      end
      return {ov, eo, fo};
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic        ev;
      logic        hs;
      int          base;
      int          w;
      int          j;
      logic [1:0]  jj;
      logic [1:0]  wi;
      logic [3:0]  exp_rdy;
      logic [31:0] r;
      exp_t        e;
      exp_rdy = '0;
      if (!rst_n) begin
         check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
         if (!prev_rst) begin
            check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
            check_eq("rst_rsp_data", {bus.rsp_ovf, bus.rsp_exp, bus.rsp_mant}, 32'd0);
         end
         exp_q.delete();
         model_ptr = 0;
      end else begin
         ev = (exp_q.size() != 0) && ((cyc - exp_q[0].cyc) >= 2);
         check_eq("busy", 32'(busy), 32'(exp_q.size() != 0));
         check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
         if (ev) begin
            check_eq("rsp_id", 32'(bus.rsp_id), 32'(exp_q[0].id));
            check_eq("rsp_mant", 32'(bus.rsp_mant), 32'(exp_q[0].mant));
            check_eq("rsp_exp", 32'(bus.rsp_exp), 32'(exp_q[0].exp));
            check_eq("rsp_ovf", 32'(bus.rsp_ovf), 32'(exp_q[0].ovf));
         end
         hs   = ev && bus.rsp_ready;
         base = hs ? ((int'(exp_q[0].id) + 1) % NReq) : model_ptr;
         w    = -1;
         if ((exp_q.size() == 0) || hs) begin
            for (int k = 0; k < NReq; k++) begin
               j  = (base + k) % NReq;
               jj = 2'(j);
               if ((w < 0) && bus.req_valid[jj]) w = j;
            end
         end
         if (w >= 0) exp_rdy = 4'(1 << w);
         check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
         if (hs) begin
            id_log.push_back(exp_q[0].id);
            hs_log.push_back(cyc);
            data_log.push_back({exp_q[0].ovf, exp_q[0].exp, exp_q[0].mant});
            model_ptr = (int'(exp_q[0].id) + 1) % NReq;
            void'(exp_q.pop_front());
         end
         if (w >= 0) begin
            wi     = 2'(w);
            r      = ref_round(tm[wi], te[wi]);
            e.id   = wi;
            e.ovf  = r[31];
            e.exp  = r[30:23];
            e.mant = r[22:0];
            e.cyc  = cyc;
            exp_q.push_back(e);
         end
      end
      prev_rst = rst_n;
      cyc++;
   end

   task automatic wait_grant(input logic [1:0] idx);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready[idx]) got = 1'b1;
      end
      check_eq("grant_seen", 32'(got), 32'd1);
      @(posedge clk);
      #1 bus.req_valid[idx] = 1'b0;
   endtask

   task automatic issue(input logic [1:0] idx, input logic [26:0] m, input logic [7:0] e);
      tm[idx] = m;
      te[idx] = e;
      bus.req_valid[idx] = 1'b1;
      wait_grant(idx);
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         #1;
         if ((exp_q.size() == 0) && !bus.rsp_valid) done = 1'b1;
      end
      check_eq("drain", 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic check_last(input string tag, input logic [1:0] id, input logic [31:0] data);
      check_eq({tag, "_id"}, 32'(id_log[id_log.size()-1]), 32'(id));
      check_eq({tag, "_data"}, data_log[data_log.size()-1], data);
   endtask

   initial begin
      int base;
      int gcnt;
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < NReq; i++) begin
         tm[i] = '0;
         te[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      rst_n = 1'b1;

      // Overflow and statistics from a fresh reset
      issue(2'd0, 27'h7FFFFFC, 8'hFE);
      wait_idle();
      check_last("ovf", 2'd0, {1'b1, 8'hFF, 23'h000000});
`ifdef FP_ROUND_SCHED_STATS_EN
      check_eq("stat_ops_1", stat_ops, 32'd1);
      check_eq("stat_ovf_1", stat_ovf, 32'd1);
`endif
      // Tie to even, round up, round up with carry into the exponent
      issue(2'd0, 27'h4000004, 8'h80);
      wait_idle();
      check_last("tie_even", 2'd0, {1'b0, 8'h80, 23'h000000});
      issue(2'd2, 27'h400000C, 8'h10);
      wait_idle();
      check_last("round_up", 2'd2, {1'b0, 8'h10, 23'h000002});
      issue(2'd1, 27'h7FFFFFC, 8'h7F);
      wait_idle();
      check_last("carry", 2'd1, {1'b0, 8'h80, 23'h000000});
`ifdef FP_ROUND_SCHED_STATS_EN
      check_eq("stat_ops_4", stat_ops, 32'd4);
      check_eq("stat_ovf_4", stat_ovf, 32'd1);
`endif

      // Round robin: all requesters valid out of reset
      @(posedge clk);
      #1 rst_n = 1'b0;
      for (int i = 0; i < NReq; i++) begin
         tm[i] = {1'b1, 26'($urandom)};
         te[i] = 8'($urandom_range(1, 200));
      end
      bus.req_valid = 4'hF;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      base = id_log.size();
      gcnt = 0;
      for (int i = 0; i < 40 && gcnt < 5; i++) begin
         @(negedge clk);
         if (bus.req_ready != 4'h0) gcnt++;
      end
      @(posedge clk);
      #1 bus.req_valid = '0;
      wait_idle();
      check_eq("rr_count", 32'(id_log.size() - base), 32'd5);
      for (int k = 0; k < 5 && (base + k) < id_log.size(); k++) begin
         check_eq("rr_order", 32'(id_log[base+k]), 32'(k % NReq));
         if (k > 0) check_eq("rr_spacing", 32'(hs_log[base+k] - hs_log[base+k-1]), 32'd2);
      end

      // Backpressure with requester 2 pending
      do_reset();
      bus.rsp_ready = 1'b0;
      issue(2'd0, {1'b1, 26'($urandom)}, 8'h55);
      tm[2] = {1'b1, 26'($urandom)};
      te[2] = 8'h66;
      bus.req_valid[2] = 1'b1;
      gcnt = 0;
      for (int i = 0; i < 10 && gcnt == 0; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) gcnt = 1;
      end
      check_eq("bp_rsp_seen", 32'(gcnt), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("bp_req_ready", 32'(bus.req_ready), 32'd0);
         check_eq("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_eq("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_release_grant", 32'(bus.req_ready), 32'h4);
      @(posedge clk);
      #1 bus.req_valid[2] = 1'b0;
      wait_idle();
      check_last("bp_req2", 2'd2, ref_round(tm[2], te[2]));

      // Reset during ROUND, then pointer restart at 0 (1 beats 3)
      issue(2'd3, {1'b1, 26'($urandom)}, 8'h44);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      base = id_log.size();
      tm[3] = {1'b1, 26'($urandom)};
      te[3] = 8'h21;
      bus.req_valid[3] = 1'b1;
      issue(2'd1, 27'h400000C, 8'h33);
      wait_grant(2'd3);
      wait_idle();
      check_eq("midrst_count", 32'(id_log.size() - base), 32'd2);
      if (id_log.size() - base >= 2) begin
         check_eq("midrst_first_id", 32'(id_log[base]), 32'd1);
         check_eq("midrst_first_data", data_log[base], {1'b0, 8'h33, 23'h000002});
         check_eq("midrst_second_id", 32'(id_log[base+1]), 32'd3);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule

// File: doc/fp_round_sched.md
Name: fp_round_sched

Overview:
- Round-robin scheduler that shares one instance of the team's combinational rounding block (module rounding: 27-bit 1.F+GRS mantissa plus 8-bit exponent in; 23-bit fraction, 8-bit exponent and overflow flag out) between N_REQ requesters.
- It sits between the normalisation stages of the FP add/mul datapaths and the pack stage.
- It registers the winning operands, evaluates rounding in a dedicated cycle and holds the result until the consumer accepts it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal clog2(N_REQ).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit set.
- req_mant  in  27*N_REQ  packed normalised mantissas; slice i = [27*i+26:27*i].
- req_exp  in  8*N_REQ  packed normalised exponents; slice i = [8*i+7:8*i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_mant  out  23  rounded fraction.
- rsp_exp  out  8  rounded exponent.
- rsp_ovf  out  1  rounding overflowed to exponent FF.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-low.
  - While rst_n=0 at a clock edge: state=IDLE, rr_ptr=0, and all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_mant, rsp_exp, rsp_ovf, busy).
  - Reset asserted in any state aborts the operation in flight. The result is discarded and rsp_valid drops after that edge.
- FSM states: IDLE, ROUND, HOLD.
- IDLE:
  - Arbiter searches req_valid starting at index rr_ptr, upward with wrap modulo N_REQ.
  - First set bit = winner w. req_ready[w]=1 combinationally in this cycle only; handshake completes this cycle.
  - At the edge: latch req_mant/req_exp slice w and id=w into op registers, then go to ROUND.
  - No request: stay in IDLE, req_ready=0.
- ROUND:
  - Rounding instance is fed only from the op registers, never directly from ports.
  - At the edge: capture rounded_mant, rounded_exp and round_causes_overflow into rsp_mant, rsp_exp and rsp_ovf; rsp_id <= op id; go to HOLD.
  - req_ready=0.
- HOLD:
  - rsp_valid=1; rsp_* stable while rsp_ready=0 (no limit on stall length).
  - On rsp_valid && rsp_ready: rr_ptr <= (rsp_id+1) mod N_REQ.
  - Same cycle, arbitration is also performed as in IDLE using the new pointer value (rsp_id+1), computed combinationally. If there is a winner: req_ready[w]=1, operands latched, go to ROUND (back-to-back). Otherwise go to IDLE.
  - req_ready=0 whenever rsp_ready=0.
- Latency: accept at edge T -> rsp_valid high from T+2. Peak throughput is one result per 2 cycles.
- Fairness: a continuously requesting requester waits at most N_REQ-1 grants.
- Requester rules: req_valid and the operand slice must stay stable until req_ready. A requester may drop req_valid before grant; it is then not served.
- rsp_id range: 0..N_REQ-1. The wrap from N_REQ-1 goes to 0, including non-power-of-2 N_REQ.
- Simultaneous events: requests arriving in ROUND are held off (req_ready=0). Reset has priority over all handshakes.

Optional Feature:
- Macro FP_ROUND_SCHED_STATS_EN.
- Defined:
  - Adds outputs stat_ops (32) and stat_ovf (32), both reset to 0.
  - stat_ops increments on each rsp handshake; stat_ovf increments on each rsp handshake with rsp_ovf=1.
  - Both counters saturate at FFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Tie-to-even: req 0 with mant 27'h4000004, exp 8'h80 -> rsp_mant 23'h000000, rsp_exp 8'h80, rsp_ovf 0, rsp_id 0, rsp_valid 2 cycles after accept.
- Round-up: mant 27'h400000C, exp 8'h10 -> rsp_mant 23'h000002, rsp_exp 8'h10. With mant 27'h7FFFFFC, exp 8'h7F -> rsp_mant 0, rsp_exp 8'h80.
- Overflow: mant 27'h7FFFFFC, exp 8'hFE -> rsp_mant 0, rsp_exp 8'hFF, rsp_ovf 1; with STATS_EN, stat_ovf=1 and stat_ops=1.
- Round-robin: all 4 requesters valid from reset, rsp_ready=1 -> rsp_id order 0,1,2,3,0; exactly one req_ready per grant; responses every 2 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles in HOLD with req 2 pending -> rsp_* unchanged, req_ready stays 0; on release, req 2 is granted in the same cycle.
- Reset mid-op: assert rst_n=0 during ROUND -> next cycle rsp_valid=0, busy=0, rr_ptr=0; the next request from req 1 returns rsp_id 1 with correct rounding.
